// File: rtl/mem_arbiter.sv
// Shares one single-ported, fixed-latency memory between instruction fetch and data accesses.
// Data has priority; a saturating count of bypassed fetches forces a fetch grant at the limit.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  FetchReq_i,
    input  logic [ADDR_WIDTH-1:0] FetchAddr_i,
    output logic [DATA_WIDTH-1:0] FetchData_o,
    output logic                  FetchValid_o,
    input  logic                  DataReq_i,
    input  logic                  DataWe_i,
    input  logic [ADDR_WIDTH-1:0] DataAddr_i,
    input  logic [DATA_WIDTH-1:0] DataWData_i,
    output logic [DATA_WIDTH-1:0] DataRData_o,
    output logic                  DataValid_o,
    output logic                  MemEn_o,
    output logic                  MemWe_o,
    output logic [ADDR_WIDTH-1:0] MemAddr_o,
    output logic [DATA_WIDTH-1:0] MemWData_o,
    input  logic [DATA_WIDTH-1:0] MemRData_i,
    output logic                  Busy_o
);
    localparam int WAIT_W   = $clog2(LATENCY + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0]   WAIT_LOAD  = WAIT_W'(LATENCY);
    localparam logic [WAIT_W-1:0]   WAIT_ONE   = WAIT_W'(1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_r;
    logic                owner_data_r;
    logic                we_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [STARVE_W-1:0] starve_cnt_r;
    logic                grant_fetch_s;
    logic                grant_data_s;

    // Grant decision for the current request pair; only acted upon in IDLE
    always_comb begin
        grant_fetch_s = FetchReq_i & (~DataReq_i | (starve_cnt_r == STARVE_MAX));
        grant_data_s  = DataReq_i & ~grant_fetch_s;
    end

    // Access sequencer with registered memory strobes, read data and completion pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            owner_data_r <= 1'b0;
            we_r         <= 1'b0;
            wait_cnt_r   <= {WAIT_W{1'b0}};
            starve_cnt_r <= {STARVE_W{1'b0}};
            FetchData_o  <= {DATA_WIDTH{1'b0}};
            FetchValid_o <= 1'b0;
            DataRData_o  <= {DATA_WIDTH{1'b0}};
            DataValid_o  <= 1'b0;
            MemEn_o      <= 1'b0;
            MemWe_o      <= 1'b0;
            MemAddr_o    <= {ADDR_WIDTH{1'b0}};
            MemWData_o   <= {DATA_WIDTH{1'b0}};
            Busy_o       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_fetch_s || grant_data_s) begin
                        state_r      <= ST_ISSUE;
                        Busy_o       <= 1'b1;
                        owner_data_r <= grant_data_s;
                        we_r         <= grant_data_s & DataWe_i;
                        MemEn_o      <= 1'b1;
                        MemWe_o      <= grant_data_s & DataWe_i;
                        MemAddr_o    <= grant_data_s ? DataAddr_i : FetchAddr_i;
                        MemWData_o   <= grant_data_s ? DataWData_i : {DATA_WIDTH{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                    // Counts data grants that overtook a waiting fetch
                    if (grant_data_s && FetchReq_i) begin
                        if (starve_cnt_r != STARVE_MAX) begin
                            starve_cnt_r <= starve_cnt_r + STARVE_ONE;
                        end else begin
                            starve_cnt_r <= starve_cnt_r;
                        end
                    end else if (grant_fetch_s || grant_data_s) begin
                        starve_cnt_r <= {STARVE_W{1'b0}};
                    end else begin
                        starve_cnt_r <= starve_cnt_r;
                    end
                end
                ST_ISSUE: begin
                    MemEn_o    <= 1'b0;
                    MemWe_o    <= 1'b0;
                    MemAddr_o  <= {ADDR_WIDTH{1'b0}};
                    MemWData_o <= {DATA_WIDTH{1'b0}};
                    if (we_r) begin
                        state_r     <= ST_RESP;
                        DataValid_o <= 1'b1;
                    end else begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= WAIT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == WAIT_ONE) begin
                        state_r <= ST_RESP;
                        if (owner_data_r) begin
                            DataRData_o <= MemRData_i;
                            DataValid_o <= 1'b1;
                        end else begin
                            FetchData_o  <= MemRData_i;
                            FetchValid_o <= 1'b1;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r - WAIT_ONE;
                    end
                end
                ST_RESP: begin
                    state_r      <= ST_IDLE;
                    Busy_o       <= 1'b0;
                    FetchValid_o <= 1'b0;
                    DataValid_o  <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    Busy_o       <= 1'b0;
                    FetchValid_o <= 1'b0;
                    DataValid_o  <= 1'b0;
                    MemEn_o      <= 1'b0;
                    MemWe_o      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, every cycle compared
// against a transaction-level timing model (grant cycle + fixed offsets per access kind).
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LAT = 2;
    localparam int SL = 4;
    localparam int NWORDS = 64;

    logic          clk = 1'b0;
    logic          rst_i, FetchReq_i, DataReq_i, DataWe_i;
    logic [AW-1:0] FetchAddr_i, DataAddr_i;
    logic [DW-1:0] DataWData_i, MemRData_i;
    logic [DW-1:0] FetchData_o, DataRData_o, MemWData_o;
    logic          FetchValid_o, DataValid_o, MemEn_o, MemWe_o, Busy_o;
    logic [AW-1:0] MemAddr_o;

    logic          l1_freq, l1_fvalid, l1_dvalid, l1_en, l1_we, l1_busy;
    logic [AW-1:0] l1_faddr, l1_addr;
    logic [DW-1:0] l1_fdata, l1_drdata, l1_wdata, l1_rdata;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic fv_seen = 1'b0;
    logic dv_seen = 1'b0;
    logic [DW-1:0] env_mem [NWORDS];
    logic [DW-1:0] model_mem [NWORDS];
    logic [DW-1:0] due_d [8];
    logic          due_v [8];

    // model state: at most one outstanding access, described by its grant and completion cycles
    logic          tx_act = 1'b0;
    logic          tx_fetch, tx_we, in_tx, e_en;
    int            tx_g, tx_end;
    int            starve = 0;
    logic [AW-1:0] tx_addr;
    logic [DW-1:0] tx_wd, tx_rd;
    logic [DW-1:0] m_fdata = 32'd0;
    logic [DW-1:0] m_ddata = 32'd0;

    logic       f_pend, d_pend, done;
    int         ng, fv_cnt;
    logic [9:0] patt;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT), .STARVE_LIMIT(SL)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .FetchReq_i(FetchReq_i), .FetchAddr_i(FetchAddr_i),
        .FetchData_o(FetchData_o), .FetchValid_o(FetchValid_o),
        .DataReq_i(DataReq_i), .DataWe_i(DataWe_i), .DataAddr_i(DataAddr_i),
        .DataWData_i(DataWData_i), .DataRData_o(DataRData_o), .DataValid_o(DataValid_o),
        .MemEn_o(MemEn_o), .MemWe_o(MemWe_o), .MemAddr_o(MemAddr_o),
        .MemWData_o(MemWData_o), .MemRData_i(MemRData_i), .Busy_o(Busy_o)
    );

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(1), .STARVE_LIMIT(SL)) u_l1 (
        .clk_i(clk), .rst_i(rst_i),
        .FetchReq_i(l1_freq), .FetchAddr_i(l1_faddr),
        .FetchData_o(l1_fdata), .FetchValid_o(l1_fvalid),
        .DataReq_i(1'b0), .DataWe_i(1'b0), .DataAddr_i(32'd0),
        .DataWData_i(32'd0), .DataRData_o(l1_drdata), .DataValid_o(l1_dvalid),
        .MemEn_o(l1_en), .MemWe_o(l1_we), .MemAddr_o(l1_addr),
        .MemWData_o(l1_wdata), .MemRData_i(l1_rdata), .Busy_o(l1_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Memory environment: read data appears exactly LAT cycles after the strobe, junk otherwise
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (MemEn_o === 1'b1) begin
            if (MemWe_o) env_mem[MemAddr_o[7:2]] = MemWData_o;
            else begin
                due_d[(cyc + LAT) % 8] = env_mem[MemAddr_o[7:2]];
                due_v[(cyc + LAT) % 8] = 1'b1;
            end
        end
        MemRData_i = due_v[cyc % 8] ? due_d[cyc % 8] : $urandom;
        due_v[cyc % 8] = 1'b0;
    end

    // Reference model and per-cycle compare
    always @(negedge clk) begin
        in_tx = tx_act && (cyc > tx_g) && (cyc <= tx_end);
        e_en  = tx_act && (cyc == tx_g + 1);
        if (tx_act && cyc == tx_end && !tx_we) begin
            if (tx_fetch) m_fdata = tx_rd;
            else m_ddata = tx_rd;
        end
        chk("busy", Busy_o, in_tx);
        chk("mem_en", MemEn_o, e_en);
        chk("mem_we", MemWe_o, e_en && tx_we);
        chk("mem_addr", MemAddr_o, e_en ? tx_addr : 32'd0);
        chk("mem_wdata", MemWData_o, e_en ? tx_wd : 32'd0);
        chk("fetch_valid", FetchValid_o, tx_act && cyc == tx_end && tx_fetch);
        chk("data_valid", DataValid_o, tx_act && cyc == tx_end && !tx_fetch);
        chk("fetch_data", FetchData_o, m_fdata);
        chk("data_rdata", DataRData_o, m_ddata);
        fv_seen = FetchValid_o;
        dv_seen = DataValid_o;
        if (rst_i) begin
            tx_act = 1'b0; m_fdata = 32'd0; m_ddata = 32'd0; starve = 0;
        end else if ((!tx_act || cyc > tx_end) && (FetchReq_i || DataReq_i)) begin
            tx_fetch = FetchReq_i && (!DataReq_i || starve == SL);
            if (tx_fetch) starve = 0;
            else if (FetchReq_i) starve = (starve < SL) ? starve + 1 : SL;
            else starve = 0;
            tx_act  = 1'b1;
            tx_g    = cyc;
            tx_we   = !tx_fetch && DataWe_i;
            tx_addr = tx_fetch ? FetchAddr_i : DataAddr_i;
            tx_wd   = tx_fetch ? 32'd0 : DataWData_i;
            tx_rd   = model_mem[tx_addr[7:2]];
            if (tx_we) model_mem[tx_addr[7:2]] = DataWData_i;
            tx_end  = cyc + (tx_we ? 2 : 2 + LAT);
        end
    end

    initial begin
        for (int i = 0; i < NWORDS; i++) begin
            env_mem[i]   = 32'h1000_0000 + i;
            model_mem[i] = 32'h1000_0000 + i;
        end
        env_mem[4] = 32'hDEAD_BEEF;
        model_mem[4] = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) due_v[i] = 1'b0;
        rst_i = 1'b1; FetchReq_i = 1'b0; DataReq_i = 1'b0; DataWe_i = 1'b0;
        FetchAddr_i = 32'd0; DataAddr_i = 32'd0; DataWData_i = 32'd0; MemRData_i = 32'd0;
        l1_freq = 1'b0; l1_faddr = 32'd0; l1_rdata = 32'd0;
        @(posedge clk); #2;
        @(posedge clk); #2; rst_i = 1'b0;
        @(negedge clk);
        chk("reset busy", Busy_o, 1'b0);
        chk("reset mem_en", MemEn_o, 1'b0);
        chk("reset fetch_data", FetchData_o, 32'd0);
        chk("reset data_rdata", DataRData_o, 32'd0);

        // fetch read of 0x10
        @(posedge clk); #2;
        FetchReq_i = 1'b1; FetchAddr_i = 32'h10;
        @(negedge clk); chk("t1 busy c0", Busy_o, 1'b0);
        @(negedge clk); chk("t1 en c1", MemEn_o, 1'b1); chk("t1 addr c1", MemAddr_o, 32'h10);
        chk("t1 busy c1", Busy_o, 1'b1);
        repeat (3) @(negedge clk);
        chk("t1 fvalid c4", FetchValid_o, 1'b1); chk("t1 fdata c4", FetchData_o, 32'hDEAD_BEEF);
        chk("t1 busy c4", Busy_o, 1'b1);
        @(posedge clk); #2; FetchReq_i = 1'b0;
        @(negedge clk); chk("t1 busy c5", Busy_o, 1'b0);

        // simultaneous requests: data load 0x40 wins, fetch 0x08 follows
        @(posedge clk); #2;
        FetchReq_i = 1'b1; FetchAddr_i = 32'h08; DataReq_i = 1'b1; DataWe_i = 1'b0; DataAddr_i = 32'h40;
        @(negedge clk); @(negedge clk);
        chk("t3 en c1", MemEn_o, 1'b1); chk("t3 addr c1", MemAddr_o, 32'h40);
        repeat (3) @(negedge clk);
        chk("t3 dvalid c4", DataValid_o, 1'b1); chk("t3 rdata c4", DataRData_o, 32'h1000_0010);
        @(posedge clk); #2; DataReq_i = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("t3 en c6", MemEn_o, 1'b1); chk("t3 addr c6", MemAddr_o, 32'h08);
        repeat (3) @(negedge clk);
        chk("t3 fvalid c9", FetchValid_o, 1'b1); chk("t3 fdata c9", FetchData_o, 32'h1000_0002);
        @(posedge clk); #2; FetchReq_i = 1'b0;

        // store 0x55 to 0x20
        @(posedge clk); #2;
        DataReq_i = 1'b1; DataWe_i = 1'b1; DataAddr_i = 32'h20; DataWData_i = 32'h55;
        @(negedge clk); @(negedge clk);
        chk("t2 en c1", MemEn_o, 1'b1); chk("t2 we c1", MemWe_o, 1'b1);
        chk("t2 wdata c1", MemWData_o, 32'h55); chk("t2 addr c1", MemAddr_o, 32'h20);
        @(negedge clk);
        chk("t2 dvalid c2", DataValid_o, 1'b1); chk("t2 rdata kept", DataRData_o, 32'h1000_0010);
        @(posedge clk); #2; DataReq_i = 1'b0; DataWe_i = 1'b0;

        // starvation guard: both held, grants D D D D F D D D D F
        @(posedge clk); #2;
        FetchReq_i = 1'b1; FetchAddr_i = 32'h80; DataReq_i = 1'b1; DataWe_i = 1'b0; DataAddr_i = 32'hC0;
        patt = 10'b10000_10000;
        ng = 0; done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (MemEn_o === 1'b1 && ng < 10) begin
                chk("starve grant order", MemAddr_o, patt[ng] ? 32'h80 : 32'hC0);
                ng++;
            end
            if (ng == 10 && FetchValid_o === 1'b1) done = 1'b1;
        end
        chk("starve run complete", done, 1'b1);
        @(posedge clk); #2; FetchReq_i = 1'b0; DataReq_i = 1'b0;

        // reset during WAIT of a fetch read
        @(posedge clk); #2; FetchReq_i = 1'b1; FetchAddr_i = 32'h14;
        @(posedge clk); #2;
        @(posedge clk); #2; rst_i = 1'b1;
        @(posedge clk); #2; rst_i = 1'b0; FetchReq_i = 1'b0;
        @(negedge clk);
        chk("rst busy c3", Busy_o, 1'b0); chk("rst en c3", MemEn_o, 1'b0);
        chk("rst fdata c3", FetchData_o, 32'd0); chk("rst rdata c3", DataRData_o, 32'd0);
        fv_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (FetchValid_o !== 1'b0) fv_cnt++;
        end
        chk("rst no fvalid", fv_cnt, 0);

        // randomized traffic with occasional reset
        f_pend = 1'b0; d_pend = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #2;
            rst_i = ($urandom_range(0, 299) == 0);
            if (!f_pend || fv_seen) begin
                f_pend = ($urandom_range(0, 2) != 0);
                FetchReq_i = f_pend;
                FetchAddr_i = 32'($urandom_range(0, NWORDS - 1)) << 2;
            end
            if (!d_pend || dv_seen) begin
                d_pend = ($urandom_range(0, 2) != 0);
                DataReq_i = d_pend;
                DataWe_i = 1'($urandom_range(0, 1));
                DataAddr_i = 32'($urandom_range(0, NWORDS - 1)) << 2;
                DataWData_i = $urandom;
            end
        end

        // LATENCY=1 instance: issue at c1, capture at c2, valid at c3
        @(posedge clk); #2; rst_i = 1'b0;
        l1_freq = 1'b1; l1_faddr = 32'h30; l1_rdata = 32'h1234_5678;
        @(posedge clk); #2;
        @(negedge clk); chk("l1 en c1", l1_en, 1'b1); chk("l1 addr c1", l1_addr, 32'h30);
        @(posedge clk); #2; l1_rdata = 32'hCAFE_F00D;
        @(negedge clk); chk("l1 fvalid c2", l1_fvalid, 1'b0); chk("l1 busy c2", l1_busy, 1'b1);
        @(posedge clk); #2; l1_rdata = 32'hFFFF_FFFF;
        @(negedge clk); chk("l1 fvalid c3", l1_fvalid, 1'b1); chk("l1 fdata c3", l1_fdata, 32'hCAFE_F00D);
        @(posedge clk); #2; l1_freq = 1'b0;
        @(negedge clk); chk("l1 busy c4", l1_busy, 1'b0); chk("l1 fvalid c4", l1_fvalid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
